// File: rtl/shreg_pkg.sv
// Shared definitions for the shreg_rs register/serialiser.
//   - MODE_* : 3-bit operation select used while the register is idle.
//   - state_t: two-state serialiser FSM encoding (idle / shifting out).
package shreg_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_CLR  = 3'b110;
    localparam logic [2:0] MODE_SET  = 3'b111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/shreg_rs.sv
// shreg_rs: WIDTH-bit general-purpose register with synchronous active-low
// reset (r) and preset (s), mode-selected load/shift/rotate/clear/set, and a
// built-in serialiser that transmits a loaded word MSB-first on sol.
//
// Ports:
//   clk   in          rising-edge clock
//   r     in          synchronous reset, active-low, highest priority
//   s     in          synchronous preset, active-low, loads PRESET, aborts transmit
//   en    in          enable for mode operations and serial shifting
//   mode  in  [2:0]   operation select while idle (see shreg_pkg)
//   start in          begin serial transmit of d (ignored while busy)
//   d     in  [W-1:0] parallel data
//   sil   in          serial input entering at the LSB (SHL and transmit)
//   sir   in          serial input entering at the MSB (SHR)
//   q     out [W-1:0] register contents
//   sol   out         q[WIDTH-1]
//   sor   out         q[0]
//   busy  out         serial transmit in progress
//   done  out         one-cycle pulse after the final serial shift
module shreg_rs
    import shreg_pkg::*;
#(
    parameter int               WIDTH  = 8,
    parameter logic [WIDTH-1:0] PRESET = '1
) (
    input  logic             clk,
    input  logic             r,
    input  logic             s,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             start,
    input  logic [WIDTH-1:0] d,
    input  logic             sil,
    input  logic             sir,
    output logic [WIDTH-1:0] q,
    output logic             sol,
    output logic             sor,
    output logic             busy,
    output logic             done
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state, state_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic [WIDTH-1:0] q_next;
    logic             done_next;

    // State register: reset beats preset, preset beats all normal operation.
    always_ff @(posedge clk) begin
        if (!r) begin
            q     <= '0;
            state <= ST_IDLE;
            cnt   <= '0;
            done  <= 1'b0;
        end else if (!s) begin
            q     <= PRESET;
            state <= ST_IDLE;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            q     <= q_next;
            state <= state_next;
            cnt   <= cnt_next;
            done  <= done_next;
        end
    end

    // Next-state / datapath mux. mode is only decoded in the idle, enabled,
    // no-start branch, so an undriven mode cannot leak into q otherwise.
    always_comb begin
        q_next     = q;
        state_next = state;
        cnt_next   = cnt;
        done_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    // Load for transmit regardless of en.
                    q_next     = d;
                    cnt_next   = '0;
                    state_next = ST_SHIFT;
                end else if (en) begin
                    case (mode)
                        MODE_HOLD: q_next = q;
                        MODE_LOAD: q_next = d;
                        MODE_SHL:  q_next = {q[WIDTH-2:0], sil};
                        MODE_SHR:  q_next = {sir, q[WIDTH-1:1]};
                        MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
                        MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
                        MODE_CLR:  q_next = '0;
                        MODE_SET:  q_next = PRESET;
                        default:   q_next = q;
                    endcase
                end
            end
            ST_SHIFT: begin
                // en=0 stalls everything; start is ignored while shifting.
                if (en) begin
                    q_next = {q[WIDTH-2:0], sil};
                    if (cnt == CNT_LAST) begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                        done_next  = 1'b1;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign sol  = q[WIDTH-1];
    assign sor  = q[0];
    assign busy = (state == ST_SHIFT);

endmodule

// File: tb/tb_shreg_rs.sv
// Self-checking bench for shreg_rs (WIDTH=8, PRESET=8'hFF).
module tb_shreg_rs;
    import shreg_pkg::*;

    logic       clk;
    logic       r, s, en, start, sil, sir;
    logic [2:0] mode;
    logic [7:0] d;
    logic [7:0] q;
    logic       sol, sor, busy, done;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    logic       exp_bit[$];

    shreg_rs #(.WIDTH(8), .PRESET(8'hFF)) dut (
        .clk(clk), .r(r), .s(s), .en(en), .mode(mode), .start(start),
        .d(d), .sil(sil), .sir(sir), .q(q), .sol(sol), .sor(sor),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling / re-driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        r = 1'b0; s = 1'b1; en = 1'b0; start = 1'b0; mode = MODE_HOLD;
        d = 8'h00; sil = 1'b0; sir = 1'b0;
        tick();
        n_cmp++;
        if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_init: q=%h busy=%b done=%b required q=00 busy=0 done=0", q, busy, done);
        end
        // Put a value in q, then assert everything at once with r=0.
        r = 1'b1; en = 1'b1; mode = MODE_LOAD; d = 8'hA5;
        tick();
        n_cmp++;
        if (q !== 8'hA5) begin
            n_err++;
            $display("FAIL reset_preload: q=%h required a5", q);
        end
        r = 1'b0; s = 1'b0; start = 1'b1; en = 1'b1; d = 8'h3C;
        tick();
        n_cmp++;
        if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_priority: q=%h busy=%b done=%b required q=00 busy=0 done=0", q, busy, done);
        end
        r = 1'b1; s = 1'b1; start = 1'b0; en = 1'b0; mode = MODE_HOLD;
        tick();
    endtask

    task automatic test_preset_abort();
        int pulses = 0;
        sil = 1'b0; en = 1'b1; mode = MODE_HOLD;
        d = 8'h3C; start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || q !== 8'h3C) begin
            n_err++;
            $display("FAIL preset_start: busy=%b q=%h required busy=1 q=3c", busy, q);
        end
        for (int i = 0; i < 3; i++) tick();
        n_cmp++;
        if (q !== 8'hE0) begin
            n_err++;
            $display("FAIL preset_3shifts: q=%h required e0", q);
        end
        s = 1'b0;
        tick();
        s = 1'b1;
        n_cmp++;
        if (q !== 8'hFF || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL preset_abort: q=%h busy=%b done=%b required q=ff busy=0 done=0", q, busy, done);
        end
        for (int i = 0; i < 10; i++) begin
            if (done === 1'b1) pulses++;
            tick();
        end
        n_cmp++;
        if (pulses != 0 || q !== 8'hFF) begin
            n_err++;
            $display("FAIL preset_no_done: done_pulses=%0d q=%h required 0 pulses q=ff", pulses, q);
        end
    endtask

    task automatic test_modes();
        logic [2:0] seq [4];
        logic [7:0] want;
        seq[0] = MODE_SHL; seq[1] = MODE_SHR; seq[2] = MODE_ROL; seq[3] = MODE_ROR;
        en = 1'b1; mode = MODE_LOAD; d = 8'h81;
        tick();
        sil = 1'b0; sir = 1'b1;
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h81);
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h81);
        for (int i = 0; i < 4; i++) begin
            mode = seq[i];
            tick();
            want = exp_q.pop_front();
            n_cmp++;
            if (q !== want) begin
                n_err++;
                $display("FAIL mode_%0d: q=%h required %h", seq[i], q, want);
            end
        end
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        mode = MODE_CLR; tick();
        want = exp_q.pop_front();
        n_cmp++;
        if (q !== want) begin
            n_err++;
            $display("FAIL mode_clr: q=%h required %h", q, want);
        end
        mode = MODE_SET; tick();
        mode = MODE_HOLD; tick();
        want = exp_q.pop_front();
        n_cmp++;
        if (q !== want || sol !== 1'b1 || sor !== 1'b1) begin
            n_err++;
            $display("FAIL mode_set_hold: q=%h sol=%b sor=%b required %h 1 1", q, sol, sor, want);
        end
    endtask

    task automatic test_serial();
        int  busy_cnt = 0;
        int  guard = 0;
        logic b;
        logic [7:0] pat = 8'hB4;
        for (int i = 7; i >= 0; i--) exp_bit.push_back(pat[i]);
        en = 1'b1; sil = 1'b0; mode = MODE_HOLD; d = 8'hB4; start = 1'b1;
        tick();
        start = 1'b0;
        while (busy === 1'b1 && guard < 40) begin
            busy_cnt++;
            if (exp_bit.size() > 0) begin
                b = exp_bit.pop_front();
                n_cmp++;
                if (sol !== b) begin
                    n_err++;
                    $display("FAIL serial_bit%0d: sol=%b required %b", busy_cnt, sol, b);
                end
            end
            guard++;
            tick();
        end
        n_cmp++;
        if (busy_cnt != 8 || done !== 1'b1 || q !== 8'h00 || exp_bit.size() != 0) begin
            n_err++;
            $display("FAIL serial_end: busy_cycles=%0d done=%b q=%h left=%0d required 8 1 00 0",
                     busy_cnt, done, q, exp_bit.size());
        end
        tick();
        n_cmp++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL serial_done_pulse: done=%b required 0", done);
        end
    endtask

    task automatic test_stall_ignored_start();
        int busy_cnt = 0;
        int guard = 0;
        en = 1'b1; sil = 1'b0; d = 8'hF0; start = 1'b1;
        tick();
        start = 1'b0;
        busy_cnt++;
        tick(); busy_cnt++;
        tick(); busy_cnt++;
        en = 1'b0;
        tick(); busy_cnt++;
        n_cmp++;
        if (q !== 8'hC0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL stall_1: q=%h busy=%b required c0 1", q, busy);
        end
        start = 1'b1; d = 8'h0F;
        tick(); busy_cnt++;
        start = 1'b0;
        n_cmp++;
        if (q !== 8'hC0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL stall_start: q=%h busy=%b required c0 1", q, busy);
        end
        tick(); busy_cnt++;
        n_cmp++;
        if (q !== 8'hC0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL stall_3: q=%h done=%b required c0 0", q, done);
        end
        en = 1'b1;
        tick();
        n_cmp++;
        if (q !== 8'h80) begin
            n_err++;
            $display("FAIL stall_resume: q=%h required 80", q);
        end
        while (busy === 1'b1 && guard < 40) begin
            busy_cnt++;
            guard++;
            tick();
        end
        n_cmp++;
        if (busy_cnt != 11 || done !== 1'b1 || q !== 8'h00) begin
            n_err++;
            $display("FAIL stall_total: busy_cycles=%0d done=%b q=%h required 11 1 00", busy_cnt, done, q);
        end
    endtask

    task automatic test_enable_gating();
        int bad = 0;
        en = 1'b0; mode = MODE_LOAD; d = 8'h55;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (q !== 8'h00) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL enable_hold: q=%h changed in %0d cycles required 00 held", q, bad);
        end
        en = 1'b1;
        tick();
        en = 1'b0;
        n_cmp++;
        if (q !== 8'h55 || sol !== 1'b0 || sor !== 1'b1) begin
            n_err++;
            $display("FAIL enable_load: q=%h sol=%b sor=%b required 55 0 1", q, sol, sor);
        end
    endtask

    initial begin
        test_reset();
        test_preset_abort();
        test_modes();
        test_serial();
        test_stall_ignored_start();
        test_enable_gating();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
